// File: rtl/udm_bus_responder.sv
// ---------------------------------------------------------------------------
// udm_bus_responder
//
// Purpose
//   Responder (slave) end of the udm debug bus. Holds a word-organised,
//   byte-writable memory of 2**ADDR_WIDTH 32-bit words mapped at BASE_ADDR.
//   Accepts a transfer after a programmable stall and returns read data
//   after a fixed latency through a shift pipeline. Serves as a target in
//   system benches and as a small scratchpad/mailbox in SoC top levels.
//
// Parameters
//   ADDR_WIDTH    log2 of memory depth in 32-bit words
//   BASE_ADDR     byte address of word 0 (4-byte aligned)
//   ACK_DELAY     cycles bus_req_i is held before bus_ack_o may assert
//   RESP_LATENCY  cycles from read transfer edge to the response (1..16)
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous reset, active high
//   bus_req_i     request, held by the initiator until accepted
//   bus_ack_o     accept, combinational from bus_req_i
//   bus_we_i      1 = write, 0 = read
//   bus_addr_bi   byte address, bits [1:0] ignored
//   bus_be_bi     write byte enables, bit n -> wdata[8n+7:8n]
//   bus_wdata_bi  write data
//   bus_resp_o    one-cycle read response strobe
//   bus_rdata_bo  read data, forced to zero while bus_resp_o is low
//   err_o         sticky out-of-range flag, cleared only by reset
//
// Handshake
//   bus_req_i acts as "valid" and bus_ack_o as "ready": a transfer happens
//   on every rising edge where both are high. The initiator keeps req and
//   the command fields stable until that edge. Read responses carry no
//   back-pressure: bus_resp_o is a single-cycle strobe that the initiator
//   must take, and responses come back strictly in request order.
// ---------------------------------------------------------------------------
module udm_bus_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned ACK_DELAY    = 0,
    parameter int unsigned RESP_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    output logic        bus_ack_o,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        err_o
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    // A zero-width counter is illegal, so ACK_DELAY=0 still gets one bit
    // (it simply never leaves zero).
    localparam int unsigned WCNT_W = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(ACK_DELAY);
    // Byte span of the memory; one extra bit so ADDR_WIDTH=30 cannot wrap.
    localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

    // -----------------------------------------------------------------------
    // Accept logic
    // -----------------------------------------------------------------------
    logic [WCNT_W-1:0] wcnt;
    logic              xfer;
    logic              rd_xfer;

    // Reset gates ack directly so nothing transfers on a reset edge, even a
    // write whose request was already pending.
    assign bus_ack_o = bus_req_i && !rst_i && (wcnt == WCNT_MAX);
    assign xfer      = bus_req_i && bus_ack_o;
    assign rd_xfer   = xfer && !bus_we_i;

    // Counts stalled request cycles; any gap in the request or a completed
    // transfer restarts the count, so each transfer pays the full stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt <= '0;
        end else if (xfer || !bus_req_i) begin
            wcnt <= '0;
        end else if (wcnt != WCNT_MAX) begin
            wcnt <= wcnt + WCNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [31:0]           off;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;

    // Unsigned subtract: addresses below BASE_ADDR wrap to a huge offset
    // and therefore fall out of range without a separate lower-bound test.
    assign off      = bus_addr_bi - BASE_ADDR;
    assign in_range = ({1'b0, off} < SPAN);
    assign idx      = off[ADDR_WIDTH+1:2];

    // -----------------------------------------------------------------------
    // Memory
    // -----------------------------------------------------------------------
    // Not reset: contents survive rst_i and start from the configuration
    // image (all zero).
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;

    // Read sees the array before this edge's write, i.e. every write from
    // earlier edges; reads and writes never share an edge anyway.
    assign rd_word = in_range ? mem[idx] : 32'h0;

    always_ff @(posedge clk_i) begin
        if (xfer && bus_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be_bi[b]) begin
                    mem[idx][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (xfer && !in_range) begin
            err_o <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Read response pipeline
    // -----------------------------------------------------------------------
    // Stage 0 is loaded at the transfer edge, so the last stage is visible
    // in the cycle that ends at the RESP_LATENCY-th edge after the transfer,
    // where the initiator samples it. One entry per cycle, never stalls.
    logic [RESP_LATENCY-1:0] pipe_vld;
    logic [31:0]             pipe_data [RESP_LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_xfer;
            for (int s = 1; s < int'(RESP_LATENCY); s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
            end
        end
    end

    // Data rides alongside without reset; the valid bit alone decides
    // whether it is ever shown on the bus.
    always_ff @(posedge clk_i) begin
        pipe_data[0] <= rd_word;
        for (int s = 1; s < int'(RESP_LATENCY); s++) begin
            pipe_data[s] <= pipe_data[s-1];
        end
    end

    assign bus_resp_o   = pipe_vld[RESP_LATENCY-1];
    assign bus_rdata_bo = pipe_vld[RESP_LATENCY-1] ? pipe_data[RESP_LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_udm_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_udm_bus_responder
//
// Directed bench for udm_bus_responder. Three instances share the command
// fields and reset but have private request lines:
//   dut 0 (a): ADDR_WIDTH=10 BASE=0x0000_0000 ACK_DELAY=0 RESP_LATENCY=2
//   dut 1 (b): ADDR_WIDTH=4  BASE=0x0000_4000 ACK_DELAY=3 RESP_LATENCY=2
//   dut 2 (c): ADDR_WIDTH=4  BASE=0x8000_0000 ACK_DELAY=0 RESP_LATENCY=5
// Inputs change 1 time unit after a rising edge; outputs are checked on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_udm_bus_responder;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared command fields ----------------
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;

    logic        a_req, b_req, c_req;
    logic        a_ack, b_ack, c_ack;
    logic        a_resp, b_resp, c_resp;
    logic [31:0] a_rdata, b_rdata, c_rdata;
    logic        a_err, b_err, c_err;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    udm_bus_responder #(
        .ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .ACK_DELAY(0), .RESP_LATENCY(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .bus_req_i(a_req), .bus_ack_o(a_ack),
        .bus_we_i(bus_we), .bus_addr_bi(bus_addr), .bus_be_bi(bus_be),
        .bus_wdata_bi(bus_wdata), .bus_resp_o(a_resp), .bus_rdata_bo(a_rdata),
        .err_o(a_err)
    );

    udm_bus_responder #(
        .ADDR_WIDTH(4), .BASE_ADDR(32'h0000_4000), .ACK_DELAY(3), .RESP_LATENCY(2)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .bus_req_i(b_req), .bus_ack_o(b_ack),
        .bus_we_i(bus_we), .bus_addr_bi(bus_addr), .bus_be_bi(bus_be),
        .bus_wdata_bi(bus_wdata), .bus_resp_o(b_resp), .bus_rdata_bo(b_rdata),
        .err_o(b_err)
    );

    udm_bus_responder #(
        .ADDR_WIDTH(4), .BASE_ADDR(32'h8000_0000), .ACK_DELAY(0), .RESP_LATENCY(5)
    ) dut_c (
        .clk_i(clk), .rst_i(rst), .bus_req_i(c_req), .bus_ack_o(c_ack),
        .bus_we_i(bus_we), .bus_addr_bi(bus_addr), .bus_be_bi(bus_be),
        .bus_wdata_bi(bus_wdata), .bus_resp_o(c_resp), .bus_rdata_bo(c_rdata),
        .err_o(c_err)
    );

    // ---------------- per-instance selectors ----------------
    function automatic logic ack_of(input int s);
        case (s)
            0:       return a_ack;
            1:       return b_ack;
            default: return c_ack;
        endcase
    endfunction

    function automatic logic resp_of(input int s);
        case (s)
            0:       return a_resp;
            1:       return b_resp;
            default: return c_resp;
        endcase
    endfunction

    function automatic logic [31:0] rdata_of(input int s);
        case (s)
            0:       return a_rdata;
            1:       return b_rdata;
            default: return c_rdata;
        endcase
    endfunction

    task automatic set_req(input int s, input logic v);
        case (s)
            0:       a_req = v;
            1:       b_req = v;
            default: c_req = v;
        endcase
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Raise req with the given command, expect ack after exactly wt stalled
    // cycles, drop req right after the transfer edge. Entered and left at
    // 1 time unit after a rising edge.
    task automatic xfer(input int s, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input int wt);
        set_req(s, 1'b1);
        bus_we    = we;
        bus_addr  = addr;
        bus_be    = be;
        bus_wdata = wd;
        for (int w = 0; w <= wt; w++) begin
            @(negedge clk);
            chk($sformatf("ack%0d@%0d", s, w), 32'(ack_of(s)), 32'(w == wt));
            @(posedge clk); #1;
        end
        set_req(s, 1'b0);
    endtask

    // Single read; the strobe must appear only in the lat-th cycle after
    // the transfer edge, with data there and zero data elsewhere.
    task automatic read_chk(input int s, input logic [31:0] addr, input logic [31:0] exp_data,
                            input int lat, input int wt);
        xfer(s, 1'b0, addr, 4'h0, 32'h0, wt);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            chk($sformatf("resp%0d_%08h@%0d", s, addr, c), 32'(resp_of(s)), 32'(c == lat));
            chk($sformatf("rdata%0d_%08h@%0d", s, addr, c), rdata_of(s),
                (c == lat) ? exp_data : 32'h0);
            @(posedge clk); #1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        a_req     = 1'b1;
        b_req     = 1'b1;
        c_req     = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 32'h0000_0010;
        bus_be    = 4'hF;
        bus_wdata = 32'hFFFF_FFFF;

        // 1: reset held 3 cycles with requests high: no accept, outputs zero
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_a_ack", 32'(a_ack), 32'h0);
            chk("rst_b_ack", 32'(b_ack), 32'h0);
            chk("rst_c_ack", 32'(c_ack), 32'h0);
            chk("rst_a_resp", 32'(a_resp), 32'h0);
            chk("rst_a_rdata", a_rdata, 32'h0);
            chk("rst_a_err", 32'(a_err), 32'h0);
            chk("rst_c_resp", 32'(c_resp), 32'h0);
            chk("rst_c_err", 32'(c_err), 32'h0);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        c_req = 1'b0;

        // 2: write then read back on the very next edge
        xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'hA5A5_1234, 0);
        read_chk(0, 32'h0000_0010, 32'hA5A5_1234, 2, 0);

        // 3: byte enables, be=0 no-op, low address bits ignored
        xfer(0, 1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 0);
        xfer(0, 1'b1, 32'h0000_0020, 4'b0101, 32'hFFFF_FFFF, 0);
        read_chk(0, 32'h0000_0020, 32'h11FF_33FF, 2, 0);
        xfer(0, 1'b1, 32'h0000_0020, 4'h0, 32'hDEAD_BEEF, 0);
        read_chk(0, 32'h0000_0023, 32'h11FF_33FF, 2, 0);
        xfer(0, 1'b1, 32'h0000_0FFC, 4'hF, 32'h600D_F00D, 0);
        read_chk(0, 32'h0000_0FFC, 32'h600D_F00D, 2, 0);
        chk("a_err_inrange", 32'(a_err), 32'h0);

        // 5: burst of 8 back-to-back reads, responses two cycles behind
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, 32'(i * 4), 4'hF, 32'hB000_0000 | 32'(i), 0);
        end
        for (int j = 0; j < 11; j++) begin
            if (j < 8) begin
                a_req    = 1'b1;
                bus_we   = 1'b0;
                bus_addr = 32'(j * 4);
                exp_q.push_back(32'hB000_0000 | 32'(j));
            end else begin
                a_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("burst_ack@%0d", j), 32'(a_ack), 32'(j < 8));
            if (j >= 2 && j < 10) begin
                chk($sformatf("burst_resp@%0d", j), 32'(a_resp), 32'h1);
                chk($sformatf("burst_data@%0d", j), a_rdata, exp_q.pop_front());
            end else begin
                chk($sformatf("burst_resp@%0d", j), 32'(a_resp), 32'h0);
                chk($sformatf("burst_data@%0d", j), a_rdata, 32'h0);
            end
            @(posedge clk); #1;
        end
        chk("a_err_after_burst", 32'(a_err), 32'h0);

        // 5: out-of-range reads and write; err sticks, word 0 untouched
        read_chk(0, 32'h0000_1000, 32'h0, 2, 0);
        chk("a_err_above", 32'(a_err), 32'h1);
        read_chk(0, 32'hFFFF_FFFC, 32'h0, 2, 0);
        chk("a_err_below", 32'(a_err), 32'h1);
        xfer(0, 1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_DEAD, 0);
        read_chk(0, 32'h0000_0000, 32'hB000_0000, 2, 0);
        chk("a_err_sticky", 32'(a_err), 32'h1);

        // 4: ACK_DELAY=3 -> ack on the 4th cycle of a held request
        xfer(1, 1'b1, 32'h0000_4008, 4'hF, 32'hCAFE_F00D, 3);
        // request for 2 cycles, then a gap: the stall count must restart
        b_req    = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 32'h0000_4008;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("b_ack_short", 32'(b_ack), 32'h0);
            @(posedge clk); #1;
        end
        b_req = 1'b0;
        @(negedge clk);
        chk("b_ack_gap", 32'(b_ack), 32'h0);
        @(posedge clk); #1;
        // held 8 cycles: two reads accepted on cycles 3 and 7
        for (int c = 0; c < 11; c++) begin
            b_req = (c < 8);
            @(negedge clk);
            chk($sformatf("b_hold_ack@%0d", c), 32'(b_ack), 32'(c == 3 || c == 7));
            chk($sformatf("b_hold_resp@%0d", c), 32'(b_resp), 32'(c == 5 || c == 9));
            chk($sformatf("b_hold_data@%0d", c), b_rdata,
                (c == 5 || c == 9) ? 32'hCAFE_F00D : 32'h0);
            @(posedge clk); #1;
        end

        // dut b range edges with a non-zero base
        xfer(1, 1'b1, 32'h0000_4000, 4'hF, 32'h5555_AAAA, 3);
        xfer(1, 1'b1, 32'h0000_403C, 4'hF, 32'h1234_5678, 3);
        read_chk(1, 32'h0000_403C, 32'h1234_5678, 2, 3);
        chk("b_err_inrange", 32'(b_err), 32'h0);
        read_chk(1, 32'h0000_4040, 32'h0, 2, 3);
        chk("b_err_above", 32'(b_err), 32'h1);
        read_chk(1, 32'h0000_3FFC, 32'h0, 2, 3);
        chk("b_err_below", 32'(b_err), 32'h1);

        // dut c: latency 5, base at 0x8000_0000
        xfer(2, 1'b1, 32'h8000_0004, 4'hF, 32'h0BAD_CAFE, 0);
        read_chk(2, 32'h8000_0004, 32'h0BAD_CAFE, 5, 0);
        read_chk(2, 32'h7FFF_FFFC, 32'h0, 5, 0);
        chk("c_err_below", 32'(c_err), 32'h1);

        // 6: three reads in flight, reset one cycle before the first
        // response (with a write pending on the reset edge)
        for (int c = 0; c < 13; c++) begin
            if (c < 3) begin
                c_req    = 1'b1;
                bus_we   = 1'b0;
                bus_addr = 32'h8000_0004;
            end else if (c == 4) begin
                c_req     = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = 32'h8000_0004;
                bus_be    = 4'hF;
                bus_wdata = 32'hFFFF_FFFF;
                rst       = 1'b1;
            end else begin
                c_req = 1'b0;
                rst   = 1'b0;
            end
            @(negedge clk);
            if (c < 3) begin
                chk($sformatf("mid_ack@%0d", c), 32'(c_ack), 32'h1);
            end else if (c == 4) begin
                chk("mid_ack_rst", 32'(c_ack), 32'h0);
            end
            chk($sformatf("mid_resp@%0d", c), 32'(c_resp), 32'h0);
            chk($sformatf("mid_data@%0d", c), c_rdata, 32'h0);
            @(posedge clk); #1;
        end
        chk("a_err_cleared", 32'(a_err), 32'h0);
        chk("b_err_cleared", 32'(b_err), 32'h0);
        chk("c_err_cleared", 32'(c_err), 32'h0);

        // memory survives reset; blocked write did not land
        read_chk(2, 32'h8000_0004, 32'h0BAD_CAFE, 5, 0);
        read_chk(0, 32'h0000_0020, 32'h11FF_33FF, 2, 0);
        read_chk(1, 32'h0000_4008, 32'hCAFE_F00D, 2, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
